// File: rtl/ysyx_22050039_imem_if.sv
// Fetch request/response bundle between the IFU (master) and the instruction memory (slave).
// The master drives the request and rsp_ready. The slave drives req_ready and the response.
interface ysyx_22050039_imem_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_inst;
  logic            rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/ysyx_22050039_imem.sv
// Instruction memory with one outstanding fetch and a fault flag; optional trace via YSYX_22050039_IMEM_TRACE_EN.
// Latency: response valid LAT cycles after the accept cycle, and the next accept can follow one cycle after the handshake.
// Backpressure: the response is held stable while rsp_ready=0, and no request is accepted until the response completes.
module ysyx_22050039_imem #(
  parameter int              XLEN  = 64,
  parameter logic [XLEN-1:0] BASE  = 64'h80000000,
  parameter int              DEPTH = 1024,
  parameter int              LAT   = 2,
  localparam int             AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_22050039_imem_if.slave    bus,
  input  logic                   ld_en,
  input  logic [AW-1:0]          ld_idx,
  input  logic [31:0]            ld_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } rsp_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic [XLEN-1:0] r_addr;
  rsp_t            r_rsp;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_done;
  logic            w_enter_resp;
  logic [XLEN-1:0] w_faddr;
  logic [XLEN-2:0] w_wdiff;
  logic            w_misal;
  logic            w_oor;
  logic            w_fault;
  logic [AW-1:0]   w_idx;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  assign w_done   = (r_state == S_RESP) && bus.rsp_ready;

  // With LAT=1 the word is sampled on the accept edge, before r_addr holds the address.
  assign w_faddr  = (r_state == S_IDLE) ? bus.req_addr : r_addr;

  // Word-granular offset from BASE with an extra borrow bit: a set MSB means addr < BASE,
  // and any set bit above the index means addr >= BASE + 4*DEPTH.
  assign w_wdiff  = {1'b0, w_faddr[XLEN-1:2]} - {1'b0, BASE[XLEN-1:2]};
  assign w_oor    = w_wdiff[XLEN-2] | (|w_wdiff[XLEN-3:AW]);
  assign w_misal  = |w_faddr[1:0];
  assign w_fault  = w_misal | w_oor;
  assign w_idx    = w_wdiff[AW-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LAT == 1) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt  = S_RESP;
          w_cnt_nxt    = 4'd0;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr <= bus.req_addr;
      end
      // Reads the pre-edge array, so a same-edge load returns the old word.
      if (w_enter_resp) begin
        r_rsp.err  <= w_fault;
        r_rsp.inst <= w_fault ? 32'h0 : r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_idx] <= ld_data;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_inst  = (r_state == S_RESP) ? r_rsp.inst : 32'h0;
  assign bus.rsp_err   = (r_state == S_RESP) ? r_rsp.err  : 1'b0;

`ifdef YSYX_22050039_IMEM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && w_done) begin
      $display("IMEM: addr=0x%x inst=0x%x err=%b", r_addr, r_rsp.inst, r_rsp.err);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050039_imem.sv
// Randomized bench for the instruction memory: a LAT=2 and a LAT=1 instance, one active at a time.
// Expected fetch results come from a plain array image and address arithmetic.
module tb_ysyx_22050039_imem;
  localparam int          XLEN  = 64;
  localparam logic [63:0] BASE  = 64'h80000000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [9:0]  ld_idx;
  logic [31:0] ld_data;

  logic        sel_lat1;
  logic        drv_req_valid;
  logic [63:0] drv_req_addr;
  logic        drv_rsp_ready;

  logic        obs_req_ready;
  logic        obs_rsp_valid;
  logic [31:0] obs_rsp_inst;
  logic        obs_rsp_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          last_acc = 0;
  int          prev_acc = 0;
  logic [31:0] mdl_mem [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_22050039_imem_if #(.XLEN(XLEN)) bus  ();
  ysyx_22050039_imem_if #(.XLEN(XLEN)) bus1 ();

  assign bus.req_valid  = drv_req_valid & ~sel_lat1;
  assign bus.req_addr   = drv_req_addr;
  assign bus.rsp_ready  = drv_rsp_ready | sel_lat1;
  assign bus1.req_valid = drv_req_valid & sel_lat1;
  assign bus1.req_addr  = drv_req_addr;
  assign bus1.rsp_ready = drv_rsp_ready | ~sel_lat1;

  assign obs_req_ready = sel_lat1 ? bus1.req_ready : bus.req_ready;
  assign obs_rsp_valid = sel_lat1 ? bus1.rsp_valid : bus.rsp_valid;
  assign obs_rsp_inst  = sel_lat1 ? bus1.rsp_inst  : bus.rsp_inst;
  assign obs_rsp_err   = sel_lat1 ? bus1.rsp_err   : bus.rsp_err;

  ysyx_22050039_imem #(.XLEN(XLEN), .BASE(BASE), .DEPTH(DEPTH), .LAT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  ysyx_22050039_imem #(.XLEN(XLEN), .BASE(BASE), .DEPTH(DEPTH), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference fetch: fault on misalignment or outside [BASE, BASE+4*DEPTH), no wrap.
  task automatic ref_fetch(input logic [63:0] a, output logic [31:0] inst, output logic err);
    logic [64:0] lim;
    logic [63:0] off;
    lim  = {1'b0, BASE} + 65'(4 * DEPTH);
    err  = (a[1:0] != 2'b00) || ({1'b0, a} < {1'b0, BASE}) || ({1'b0, a} >= lim);
    off  = (a - BASE) >> 2;
    inst = err ? 32'h0 : mdl_mem[off[9:0]];
  endtask

  // All tasks start and end just after a falling edge.
  task automatic ld_word(input int idx, input logic [31:0] dat);
    ld_en   = 1'b1;
    ld_idx  = 10'(idx);
    ld_data = dat;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mdl_mem[idx] = dat;
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [63:0] a, input int stall, input bit coll,
                          input int cidx, input logic [31:0] cdat);
    logic [31:0] ei;
    logic        ee;
    int          lat;
    lat = sel_lat1 ? 1 : 2;
    ref_fetch(a, ei, ee);
    drv_rsp_ready = (stall == 0);
    drv_req_valid = 1'b1;
    drv_req_addr  = a;
    check_val("req_ready_idle", obs_req_ready, 1);
    @(posedge clk); #1;
    prev_acc = last_acc;
    last_acc = cyc;
    drv_req_valid = 1'b0;
    drv_req_addr  = {$urandom, $urandom};
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      check_val("req_ready_busy", obs_req_ready, 0);
      if (n < lat) begin
        check_val("valid_early", obs_rsp_valid, 0);
        check_val("inst_idle_zero", obs_rsp_inst, 0);
        check_val("err_idle_zero", obs_rsp_err, 0);
        if (coll && n == lat - 1) begin
          ld_en = 1'b1; ld_idx = 10'(cidx); ld_data = cdat;
        end
        @(posedge clk); #1;
        if (coll && n == lat - 1) begin
          ld_en = 1'b0;
          mdl_mem[cidx] = cdat;
        end
      end else begin
        check_val("valid_at_lat", obs_rsp_valid, 1);
        check_val("rsp_inst", obs_rsp_inst, ei);
        check_val("rsp_err", obs_rsp_err, ee);
      end
    end
    for (int s = 1; s < stall; s++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_val("hold_valid", obs_rsp_valid, 1);
      check_val("hold_inst", obs_rsp_inst, ei);
      check_val("hold_err", obs_rsp_err, ee);
      check_val("hold_req_ready", obs_req_ready, 0);
    end
    if (stall > 0) begin
      @(posedge clk); #1;
      drv_rsp_ready = 1'b1;
      @(negedge clk);
      check_val("final_valid", obs_rsp_valid, 1);
      check_val("final_inst", obs_rsp_inst, ei);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check_val("post_req_ready", obs_req_ready, 1);
    check_val("post_valid", obs_rsp_valid, 0);
    check_val("post_inst", obs_rsp_inst, 0);
    check_val("post_err", obs_rsp_err, 0);
  endtask

  // Reset d cycles after the accept edge: d=1 lands in WAIT, d=2 in RESP (held by rsp_ready=0).
  task automatic reset_mid(input int d);
    sel_lat1      = 1'b0;
    drv_req_valid = 1'b1;
    drv_req_addr  = BASE + 64'd4;
    @(posedge clk); #1;
    drv_req_valid = 1'b0;
    drv_rsp_ready = 1'b0;
    for (int k = 1; k < d; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drv_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("rst_mid_no_valid", obs_rsp_valid, 0);
      check_val("rst_mid_ready", obs_req_ready, 1);
    end
  endtask

  logic [63:0] a;
  logic [31:0] rv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    sel_lat1 = 1'b0;
    drv_req_valid = 1'b0; drv_req_addr = '0; drv_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Image load with reset held: writes must land regardless of reset.
    for (int i = 0; i < DEPTH; i++) begin
      rv = (i == 0) ? 32'h00000413 : $urandom;
      ld_word(i, rv);
    end
    check_val("rst_req_ready", bus.req_ready, 1);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_rsp_inst", bus.rsp_inst, 0);
    check_val("rst_rsp_err", bus.rsp_err, 0);
    check_val("rst1_req_ready", bus1.req_ready, 1);
    check_val("rst1_rsp_valid", bus1.rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    do_fetch(BASE, 0, 0, 0, 0);
    check_val("first_inst_via_model", mdl_mem[0], 32'h00000413);
    do_fetch(BASE + 64'd8, 4, 0, 0, 0);
    do_fetch(64'h80000002, 0, 0, 0, 0);
    do_fetch(64'h80001000, 1, 0, 0, 0);
    do_fetch(64'h7FFFFFFC, 0, 0, 0, 0);
    do_fetch(64'h80000FFC, 0, 0, 0, 0);
    do_fetch(64'hFFFFFFFF_FFFFFFFC, 0, 0, 0, 0);

    reset_mid(1);
    do_fetch(BASE + 64'd4, 0, 0, 0, 0);
    reset_mid(2);
    do_fetch(BASE + 64'd4, 2, 0, 0, 0);

    do_fetch(64'h8000000C, 0, 1, 3, 32'hDEADBEEF);
    do_fetch(64'h8000000C, 0, 0, 0, 0);
    check_val("collision_new_word", mdl_mem[3], 32'hDEADBEEF);

    sel_lat1 = 1'b1;
    do_fetch(BASE + 64'd16, 0, 0, 0, 0);
    do_fetch(BASE + 64'd20, 0, 0, 0, 0);
    check_val("lat1_b2b_period", 64'(last_acc - prev_acc), 2);
    do_fetch(64'h80000001, 0, 0, 0, 0);
    check_val("lat1_b2b_period2", 64'(last_acc - prev_acc), 2);
    do_fetch(64'h8000000C, 3, 0, 0, 0);

    for (int it = 0; it < 200; it++) begin
      sel_lat1 = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
        1: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 3));
        2: a = BASE - 64'(4 * $urandom_range(1, 1000));
        3: a = BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 1000));
        default: a = {$urandom, $urandom};
      endcase
      do_fetch(a, $urandom_range(0, 3), 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_22050039_imem.md
YSYX_22050039_IMEM -- requirements
Module: ysyx_22050039_IMEM

Interface
REQ-001 SHALL have parameter XLEN, default 64: width of the fetch address.
REQ-002 SHALL have parameter BASE, default 64'h80000000: byte address of word 0.
REQ-003 SHALL have parameter DEPTH, default 1024: number of 32-bit words; power of two.
REQ-004 SHALL have parameter LAT, default 2: request-accept to response cycles; legal range 1..15.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1 bit: IFU presents a fetch address.
REQ-008 SHALL have port req_ready, output, 1 bit: the block accepts a request.
REQ-009 SHALL have port req_addr, input, XLEN bits: fetch byte address (the IFU pc).
REQ-010 SHALL have port rsp_valid, output, 1 bit: rsp_inst and rsp_err are valid.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the consumer takes the response.
REQ-012 SHALL have port rsp_inst, output, 32 bits: fetched instruction word.
REQ-013 SHALL have port rsp_err, output, 1 bit: fetch fault (misaligned or out of range).
REQ-014 SHALL have ports ld_en (in, 1), ld_idx (in, log2(DEPTH)) and ld_data (in, 32): the image-load write port.

Function
REQ-015 SHALL have states IDLE, WAIT and RESP, and one outstanding request at most.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-017 SHALL register req_addr at accept; later req_addr changes do not affect the pending fetch.
REQ-018 SHALL, on accept, go to RESP when LAT=1, else to WAIT with a counter loaded to LAT-1.
REQ-019 SHALL, in WAIT, decrement the counter every cycle and enter RESP when it reaches 1.
REQ-020 SHALL assert rsp_valid first in cycle T+LAT for an accept edge at T.
REQ-021 SHALL sample the memory word on the edge that enters RESP; a same-edge ld_en write to that word is not visible (old data is returned).
REQ-022 SHALL flag misalignment when the address is not word-aligned (addr[1:0]!=0).
REQ-023 SHALL flag out-of-range when addr<BASE or addr>=BASE+4*DEPTH, computed at full XLEN width with no wrap.
REQ-024 SHALL, on either fault, return rsp_err=1 and rsp_inst=32'h0; otherwise rsp_err=0 and rsp_inst=mem[(addr-BASE)>>2].
REQ-025 SHALL hold rsp_valid, rsp_inst and rsp_err stable in RESP while rsp_ready=0.
REQ-026 SHALL return to IDLE on the edge where rsp_valid and rsp_ready are both 1.
REQ-027 SHALL NOT accept a request in the same cycle a response completes; the minimum request period is LAT+1 cycles.
REQ-028 SHALL drive rsp_inst=0 and rsp_err=0 whenever rsp_valid=0.
REQ-029 SHALL accept ld_en writes in any state, writing mem[ld_idx]=ld_data on the edge.

Reset
REQ-030 SHALL, while rst=1 on an edge, enter IDLE, clear the counter and drive rsp_valid=0, rsp_inst=0, rsp_err=0 and req_ready=1 after the edge.
REQ-031 SHALL drop any pending request on rst in WAIT or RESP; no response is produced for it.
REQ-032 SHALL NOT clear memory contents on rst; ld_en writes while rst=1 still take effect.

Configuration
REQ-033 SHALL, with YSYX_22050039_IMEM_TRACE_EN defined, print "IMEM: addr=0x%x inst=0x%x err=%b" once per completed response handshake.
REQ-034 SHALL, without YSYX_22050039_IMEM_TRACE_EN, contain no display statements; all other behaviour is identical.

Verification
REQ-035 SHALL cover this scenario: LAT=2, mem[0]=32'h00000413; request 0x80000000 accepted at cycle 5 with rsp_ready=1 -> rsp_valid=1 in cycle 7 with inst 0x00000413 and err=0, then req_ready=1 in cycle 8.
REQ-036 SHALL cover backpressure: rsp_ready=0 for 4 cycles in RESP -> rsp_valid and inst held constant, then the handshake on the 5th cycle -> IDLE.
REQ-037 SHALL cover faults: request 0x80000002 -> err=1 with inst=0; request 0x80001000 (DEPTH=1024) -> err=1; request 0x7FFFFFFC -> err=1.
REQ-038 SHALL cover reset in WAIT: rst pulsed the cycle after accept -> no rsp_valid for that request, and a fresh request still works with LAT timing.
REQ-039 SHALL cover load collision: ld_en to word 3 with 0xDEADBEEF on the RESP-entry edge of a fetch of 0x8000000C -> old word returned, and the next fetch returns 0xDEADBEEF.
REQ-040 SHALL cover LAT=1: accept at cycle T -> rsp_valid at T+1; back-to-back requests accepted every 2 cycles.
